// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full adder is reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADDER_SUB_EN enables subtraction; without it every op is a+b.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             r_carry;
    logic             r_c_msb;
    logic             r_sub;
    logic [CW-1:0]    r_cnt;
    logic             w_op;
    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_op = op;
`else
    // op stays on the port for a uniform interface but is masked off here.
    assign w_op = op & 1'b0;
`endif

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .i_a (r_a_sr[0]),
        .i_b (r_b_sr[0] ^ r_sub),
        .i_c (r_carry),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Result fields are forced to zero outside DONE so nothing stale is visible.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        result    = '0;
        cout      = 1'b0;
        ovf       = 1'b0;
        if (r_state == S_DONE) begin
            result = r_sr;
            cout   = r_carry;
            ovf    = r_c_msb ^ r_carry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sr    <= '0;
            r_carry <= 1'b0;
            r_c_msb <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_sub   <= w_op;
                        r_carry <= w_op;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_carry <= w_fa_c;
                    r_sr    <= {w_fa_s, r_sr[WIDTH-1:1]};
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    // Carry into the MSB is needed for the overflow flag.
                    if (w_last) r_c_msb <= r_carry;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model, per-cycle
// compare process, directed literal cases, reset/hold cases and random traffic.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    bit cmp_en = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic from the operand values, timing as a cycle countdown.
    logic [W-1:0] m_r;
    logic         m_c;
    logic         m_o;
    bit           m_done = 1'b0;
    int           m_left = 0;

    function automatic void model_compute(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic top);
        logic sub;
        int   ua, ub;
`ifdef SERIAL_ADDER_SUB_EN
        sub = top;
`else
        sub = 1'b0 & top;
`endif
        ua = int'(ta);
        ub = int'(tb);
        if (sub) begin
            m_r = W'(ua - ub);
            m_c = (ua >= ub);
            m_o = (ta[W-1] != tb[W-1]) && (m_r[W-1] != ta[W-1]);
        end else begin
            m_r = W'(ua + ub);
            m_c = ((ua + ub) >= (1 << W));
            m_o = (ta[W-1] == tb[W-1]) && (m_r[W-1] != ta[W-1]);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_done = 1'b0;
            m_left = 0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (in_valid) begin
            model_compute(a, b, op);
            m_left = W;
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!m_done && m_left == 0));
            check("out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) begin
                check("result", 32'(result), 32'(m_r));
                check("cout", 32'(cout), 32'(m_c));
                check("ovf", 32'(ovf), 32'(m_o));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top);
        int n;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        op = top;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic top, input logic [W-1:0] er, input logic ec,
                            input logic eo);
        int lat;
        send(ta, tb, top);
        wait_result(lat);
        check({name, "_latency"}, 32'(lat), 32'(W));
        check({name, "_result"}, 32'(result), 32'(er));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
        handshake();
    endtask

    initial begin
        logic [W-1:0] hr;
        logic         hc, ho;
        int           lat;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        directed("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        directed("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
        directed("opign_10_20", 8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
        directed("opign_80_01", 8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0);
`endif

        // Back-pressure: fields hold, new operands are refused.
        send(8'h5A, 8'h33, 1'b0);
        wait_result(lat);
        hr = result;
        hc = cout;
        ho = ovf;
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        op = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hold_result", 32'(result), 32'(hr));
            check("hold_cout", 32'(cout), 32'(hc));
            check("hold_ovf", 32'(ovf), 32'(ho));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake();
        check("hold_release_ready", 32'(in_ready), 32'd1);
        check("hold_release_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of RUN discards the operation.
        send(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_result", 32'(result), 32'd0);
        check("mrst_cout", 32'(cout), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            check("mrst_no_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        directed("post_rst_add", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Random traffic with random back-pressure; the compare process checks every cycle.
        repeat (3000) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            op = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("random_ops_seen", 32'(n_acc > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
